// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stages: default widths, the handler PC,
// occupancy codes and the per-entry header layout.
package pipe_pkg;

    localparam int          PC_W_DEFAULT   = 32;
    localparam int          EXC_W_DEFAULT  = 5;
    localparam logic [31:0] EXC_PC_DEFAULT = 32'h0000_4180;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    // State codes double as the occupancy count presented on occ.
    typedef enum logic [1:0] {
        ST_EMPTY = OCC_EMPTY,
        ST_ONE   = OCC_ONE,
        ST_FULL  = OCC_FULL
    } stage_state_e;

    typedef struct packed {
        logic [PC_W_DEFAULT-1:0]  pc;
        logic [EXC_W_DEFAULT-1:0] exc_code;
        logic                     bd;
    } stage_hdr_t;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: a load-enabled register whose synchronous
// clear forces a caller-chosen value and wins over load.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [W-1:0] clr_val,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] slot_d;
    logic [W-1:0] slot_q;

    always_comb begin
        slot_d = slot_q;
        if (clr) begin
            slot_d = clr_val;
        end else if (load) begin
            slot_d = d;
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign q = slot_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage carrying PC, exception code, delay-slot flag and payload,
// with an optional skid entry so in_ready is registered, plus an exception flush.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int              DATA_W  = 128,
    parameter int              PC_W    = PC_W_DEFAULT,
    parameter int              EXC_W   = EXC_W_DEFAULT,
    parameter logic [PC_W-1:0] EXC_PC  = PC_W'(EXC_PC_DEFAULT),
    parameter bit              SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic              in_bd,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic              out_bd,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occ
);

    localparam int SLOT_W = PC_W + EXC_W + 1 + DATA_W;

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic              in_xfer;
    logic              out_xfer;
    logic              head_clr;
    logic              head_load;
    logic              skid_clr;
    logic              skid_load;
    logic [SLOT_W-1:0] head_clr_val;
    logic [SLOT_W-1:0] head_d;
    logic [SLOT_W-1:0] head_q;
    logic [SLOT_W-1:0] skid_q;
    logic [SLOT_W-1:0] in_slot;

    assign in_slot  = {in_pc, in_exc_code, in_bd, in_data};
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Without the skid entry the stage is a plain register: only EMPTY and ONE are used.
    always_comb begin
        state_d   = state_q;
        head_load = 1'b0;
        head_d    = in_slot;
        skid_load = 1'b0;
        if (req) begin
            state_d = ST_EMPTY;
        end else if (SKID_EN) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        state_d   = ST_ONE;
                        head_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        head_load = 1'b1;
                    end else if (in_xfer) begin
                        state_d   = ST_FULL;
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        state_d   = ST_ONE;
                        head_load = 1'b1;
                        head_d    = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end else begin
            if (in_xfer) begin
                state_d   = ST_ONE;
                head_load = 1'b1;
            end else if (out_xfer) begin
                state_d = ST_EMPTY;
            end
        end
        in_ready_d = (state_d != ST_FULL);
    end

    // A flush leaves the handler PC in the head so the bubble still shows a meaningful PC.
    always_comb begin
        head_clr = rst || req;
        skid_clr = rst || req;
        if (rst) begin
            head_clr_val = '0;
        end else begin
            head_clr_val = {EXC_PC, {(EXC_W + 1 + DATA_W){1'b0}}};
        end
    end

    always_comb begin
        out_valid = (state_q != ST_EMPTY);
        occ       = state_q;
        if (SKID_EN) begin
            in_ready = in_ready_q;
        end else begin
            in_ready = out_ready || !out_valid;
        end
    end

    pipe_slot #(
        .W(SLOT_W)
    ) u_head (
        .clk    (clk),
        .clr    (head_clr),
        .clr_val(head_clr_val),
        .load   (head_load),
        .d      (head_d),
        .q      (head_q)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_slot #(
                .W(SLOT_W)
            ) u_skid (
                .clk    (clk),
                .clr    (skid_clr),
                .clr_val({SLOT_W{1'b0}}),
                .load   (skid_load),
                .d      (in_slot),
                .q      (skid_q)
            );
        end else begin : g_no_skid
            assign skid_q = '0;
        end
    endgenerate

    assign {out_pc, out_exc_code, out_bd, out_data} = head_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a bounded-FIFO model predicts occupancy, handshakes,
// head fields and bubble PC under directed and random traffic; a second instance is the SKID_EN=0 build.
`timescale 1ns/1ps
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int          DW     = 32;
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    typedef struct packed {
        logic [31:0]   pc;
        logic [4:0]    exc;
        logic          bd;
        logic [DW-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_pc;
    logic [4:0]    in_exc;
    logic          in_bd;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [4:0]    out_exc;
    logic          out_bd;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    logic          b_req;
    logic          b_in_valid;
    logic          b_in_ready;
    logic [31:0]   b_in_pc;
    logic          b_out_valid;
    logic          b_out_ready;
    logic [31:0]   b_out_pc;
    logic [4:0]    b_out_exc;
    logic          b_out_bd;
    logic [DW-1:0] b_out_data;
    logic [1:0]    b_occ;

    int    checks = 0;
    int    errors = 0;
    item_t model_q[$];
    item_t bubble = '0;
    item_t mon_head;
    logic [1:0] flush_kind = 2'd0;

    always #5 clk = ~clk;

    pipe_stage_skid #(
        .DATA_W (DW),
        .SKID_EN(1'b1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_exc_code (in_exc),
        .in_bd       (in_bd),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_exc_code(out_exc),
        .out_bd      (out_bd),
        .out_data    (out_data),
        .occ         (occ)
    );

    pipe_stage_skid #(
        .DATA_W (DW),
        .SKID_EN(1'b0)
    ) dut_noskid (
        .clk         (clk),
        .rst         (rst),
        .req         (b_req),
        .in_valid    (b_in_valid),
        .in_ready    (b_in_ready),
        .in_pc       (b_in_pc),
        .in_exc_code (5'd3),
        .in_bd       (1'b0),
        .in_data     (32'hA5A5_0000),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_pc      (b_out_pc),
        .out_exc_code(b_out_exc),
        .out_bd      (b_out_bd),
        .out_data    (b_out_data),
        .occ         (b_occ)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [4:0] exc,
                                 input logic bd, input logic ordy, input logic rq);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        in_valid  = v;
        in_pc     = pc;
        in_exc    = exc;
        in_bd     = bd;
        in_data   = $urandom;
        out_ready = ordy;
        req       = rq;
    endtask

    // Input side: every accepted item enters the model; flushes are handed to the monitor.
    always @(posedge clk) begin
        flush_kind <= rst ? 2'd1 : (req ? 2'd2 : 2'd0);
        if (!rst && !req && in_valid && in_ready) begin
            model_q.push_back('{pc: in_pc, exc: in_exc, bd: in_bd, data: in_data});
        end
    end

    // Output side: compare the DUT against the model, popping on each consumed item.
    always @(negedge clk) begin
        if (flush_kind != 2'd0) begin
            model_q.delete();
            if (flush_kind == 2'd1) begin
                bubble = '0;
            end else begin
                bubble = '{pc: EXC_PC, exc: 5'd0, bd: 1'b0, data: '0};
            end
        end
        if (!rst) begin
            checkOutput("occ", 64'(occ), 64'(model_q.size()));
            checkOutput("out_valid", 64'(out_valid), 64'(model_q.size() != 0));
            checkOutput("in_ready", 64'(in_ready), 64'(model_q.size() < 2));
            if (model_q.size() != 0) begin
                mon_head = model_q[0];
                checkOutput("head_pc", 64'(out_pc), 64'(mon_head.pc));
                checkOutput("head_exc", 64'(out_exc), 64'(mon_head.exc));
                checkOutput("head_bd", 64'(out_bd), 64'(mon_head.bd));
                checkOutput("head_data", 64'(out_data), 64'(mon_head.data));
                if (out_valid && out_ready) begin
                    void'(model_q.pop_front());
                    bubble = mon_head;
                end
            end else begin
                checkOutput("bubble_pc", 64'(out_pc), 64'(bubble.pc));
                checkOutput("bubble_exc", 64'(out_exc), 64'(bubble.exc));
                checkOutput("bubble_bd", 64'(out_bd), 64'(bubble.bd));
                checkOutput("bubble_data", 64'(out_data), 64'(bubble.data));
            end
        end
    end

    task automatic randomPhase(input int cycles);
        logic held;
        int   ready_pct;
        ready_pct = 50;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            held = in_valid && !in_ready && !rst && !req;
            #1;
            if (i % 200 == 0) ready_pct = $urandom_range(10, 100);
            rst       = ($urandom_range(0, 499) == 0);
            req       = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(1, 100) <= ready_pct);
            if (!held) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = $urandom & 32'hFFFF_FFFC;
                in_exc   = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'd0;
                in_bd    = 1'($urandom);
                in_data  = $urandom;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic drained;
        rst = 1'b1; req = 1'b0; in_valid = 1'b1; in_pc = 32'h1111; in_exc = 5'd0;
        in_bd = 1'b0; in_data = '0; out_ready = 1'b0;
        b_req = 1'b0; b_in_valid = 1'b0; b_in_pc = '0; b_out_ready = 1'b0;

        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
        checkOutput("rst_occ", 64'(occ), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(1'b1, 32'h3000, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(i < 2, 32'h3004 + 32'(4 * i), 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_pc", 64'(out_pc), 64'(32'h3000 + 32'(4 * i)));
            checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
            checkOutput("stream_occ", 64'(occ), 64'd1);
        end
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);

        applyStimulus(1'b1, 32'h3000, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3004, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_full_occ", 64'(occ), 64'd2);
        checkOutput("bp_full_in_ready", 64'(in_ready), 64'd0);
        checkOutput("bp_full_pc", 64'(out_pc), 64'h3000);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("bp_second_pc", 64'(out_pc), 64'h3004);
        checkOutput("bp_second_occ", 64'(occ), 64'd1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("bp_empty_occ", 64'(occ), 64'd0);
        checkOutput("bp_empty_in_ready", 64'(in_ready), 64'd1);

        applyStimulus(1'b1, 32'h3010, 5'd0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3014, 5'd12, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h3018, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("flush_pre_occ", 64'(occ), 64'd2);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_out_pc", 64'(out_pc), 64'(EXC_PC));
        checkOutput("flush_out_exc", 64'(out_exc), 64'd0);
        checkOutput("flush_occ", 64'(occ), 64'd0);
        checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 32'h3030, 5'd5, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("flush_drop_occ", 64'(occ), 64'd0);
        checkOutput("flush_drop_pc", 64'(out_pc), 64'(EXC_PC));

        applyStimulus(1'b1, 32'h3020, 5'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("drain_out_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_out_pc", 64'(out_pc), 64'h3020);
        checkOutput("drain_out_bd", 64'(out_bd), 64'd1);

        randomPhase(3000);

        @(posedge clk);
        #1;
        rst = 1'b0; req = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 8 && !drained; i++) begin
            @(negedge clk);
            drained = (occ == 2'd0);
        end
        checkOutput("final_drain_occ", 64'(occ), 64'd0);
        checkOutput("final_model_empty", 64'(model_q.size()), 64'd0);

        @(posedge clk);
        #1;
        b_in_valid = 1'b1; b_in_pc = 32'h5000; b_out_ready = 1'b0;
        @(negedge clk);
        checkOutput("b_empty_in_ready", 64'(b_in_ready), 64'd1);
        @(posedge clk);
        #1;
        b_in_pc = 32'h5004;
        @(negedge clk);
        checkOutput("b_loaded_valid", 64'(b_out_valid), 64'd1);
        checkOutput("b_loaded_pc", 64'(b_out_pc), 64'h5000);
        checkOutput("b_stall_in_ready", 64'(b_in_ready), 64'd0);
        checkOutput("b_loaded_occ", 64'(b_occ), 64'd1);
        @(posedge clk);
        #1;
        b_out_ready = 1'b1;
        @(negedge clk);
        checkOutput("b_comb_in_ready", 64'(b_in_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            b_in_pc    = 32'h5008 + 32'(4 * i);
            b_in_valid = (i < 2);
            @(negedge clk);
            checkOutput("b_pass_pc", 64'(b_out_pc), 64'(32'h5004 + 32'(4 * i)));
            checkOutput("b_pass_valid", 64'(b_out_valid), 64'd1);
            checkOutput("b_pass_in_ready", 64'(b_in_ready), 64'd1);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("b_drain_valid", 64'(b_out_valid), 64'd0);
        checkOutput("b_drain_occ", 64'(b_occ), 64'd0);
        checkOutput("b_drain_pc", 64'(b_out_pc), 64'h500C);
        @(posedge clk);
        #1;
        b_in_valid = 1'b1; b_in_pc = 32'h5100; b_out_ready = 1'b0;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0; b_req = 1'b1;
        @(posedge clk);
        #1;
        b_req = 1'b0;
        @(negedge clk);
        checkOutput("b_flush_valid", 64'(b_out_valid), 64'd0);
        checkOutput("b_flush_pc", 64'(b_out_pc), 64'(EXC_PC));
        checkOutput("b_flush_exc", 64'(b_out_exc), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed E->M pipeline register: one valid/ready elastic pipeline stage carrying PC, exception code, branch-delay flag and an opaque payload.
- Replaces the global stall-enable with a per-stage handshake and a 2-entry skid buffer, so the upstream ready is registered and cuts the combinational ready path.
- Keeps the exception flush (req), which empties the stage and presents the handler PC as the bubble's PC.
- Instantiated between any two pipeline stages (D/E, E/M, M/W).

Parameters:
- DATA_W, 128: payload width in bits (all non-PC, non-exception control and data fields, concatenated by the instantiating stage).
- PC_W, 32: PC width.
- EXC_W, 5: exception code width.
- EXC_PC, 32'h00004180: PC loaded into the output on req.
- SKID_EN, 1: 1 = 2-entry skid with registered in_ready; 0 = single register with combinational in_ready.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  exception/interrupt flush; synchronous.
- in_valid  in  1  upstream has a valid item.
- in_ready  out  1  stage accepts the item this cycle.
- in_pc  in  PC_W  item PC.
- in_exc_code  in  EXC_W  pending exception code (0 = none).
- in_bd  in  1  item is in a branch delay slot.
- in_data  in  DATA_W  payload.
- out_valid  out  1  output register holds a valid item.
- out_ready  in  1  downstream consumes the item this cycle.
- out_pc  out  PC_W  head item PC, or the macroscopic bubble PC.
- out_exc_code  out  EXC_W  head exception code.
- out_bd  out  1  head delay-slot flag.
- out_data  out  DATA_W  head payload.
- occ  out  2  occupancy: 0, 1 or 2.

Behaviour:
- Handshake:
  - Transfer in when in_valid && in_ready.
  - Transfer out when out_valid && out_ready.
  - out_* fields are stable while out_valid && !out_ready.
- Storage: a head register (drives out_*) and, when SKID_EN=1, a skid register of identical fields.
- FSM (SKID_EN=1), states EMPTY (occ=0), ONE (occ=1), FULL (occ=2):
  - EMPTY: in xfer -> head<=in, go to ONE; otherwise stay.
  - ONE, in xfer and out xfer: head<=in, stay ONE.
  - ONE, in xfer only: skid<=in, go to FULL.
  - ONE, out xfer only: go to EMPTY; head fields hold their value, out_valid=0.
  - ONE, neither: stay.
  - FULL: in_ready=0. Out xfer -> head<=skid, go to ONE; otherwise stay.
- in_ready is registered: 1 iff the next state is not FULL, so it is never combinationally dependent on out_ready.
- Latency: 1 cycle from in xfer to out_valid when the stage is empty. No bubbles at full throughput (in_valid=out_ready=1 continuously gives 1 item/cycle).
- SKID_EN=0:
  - in_ready = out_ready || !out_valid (combinational).
  - On in xfer, head<=in and out_valid<=1.
  - On out xfer without in xfer, out_valid<=0.
  - occ is 0 or 1.
- Priority each cycle: rst > req > handshake.
- rst:
  - out_valid=0, out_pc=0, out_exc_code=0, out_bd=0, out_data=0.
  - Skid cleared, occ=0, in_ready=1 (SKID_EN=1).
- req:
  - All entries discarded (head and skid), occ=0, out_valid=0.
  - out_pc=EXC_PC; out_exc_code=0, out_bd=0, out_data=0.
  - in_ready=1 next cycle.
  - An in xfer coinciding with req is dropped; an out xfer coinciding with req still counts as consumed downstream.
- Bubble PC: while out_valid=0, out_pc holds the last loaded value (EXC_PC after req, 0 after rst, last head PC after a drain), so CP0 always sees a macroscopic PC.
- No overflow is possible: in_ready=0 in FULL. Upstream must hold in_* stable while in_valid && !in_ready.

Decomposition:
- Shared package pipe_pkg:
  - EXC_PC_DEFAULT = 32'h00004180.
  - EXC_W_DEFAULT = 5.
  - PC_W_DEFAULT = 32.
  - occupancy localparams OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
  - packed struct stage_hdr_t {pc, exc_code, bd}.
- One natural sub-module, pipe_slot: a single load-enabled register of {hdr, data} with synchronous clear-to-value. It is instantiated twice (head, skid); the skid instance is omitted under SKID_EN=0.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_pc=0, occ=0, in_ready=1; first in xfer after release gives out_valid=1 next cycle.
- Streaming: in_pc 0x3000, 0x3004, 0x3008 on consecutive cycles, out_ready=1 -> same PCs out one cycle later, back-to-back, in_ready never drops, occ=1.
- Backpressure: out_ready=0 while sending 0x3000 then 0x3004 -> occ=2, in_ready=0 the cycle after 0x3004 is accepted, out_pc stays 0x3000; raise out_ready -> 0x3000 then 0x3004 out in order, occ 2->1->0, in_ready returns to 1.
- Exception flush: occ=2 with items 0x3010/0x3014 (exc_code 12 on 0x3014), pulse req with in_valid=1 -> next cycle out_valid=0, out_pc=0x00004180, out_exc_code=0, occ=0, input item dropped.
- Drain hold: single item pc 0x3020 bd=1 consumed with no new input -> out_valid=0, out_pc stays 0x3020, out_bd stays 1.
- SKID_EN=0 build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 with in_valid=1 -> pass-through at 1 item/cycle.
